// File: rtl/mobo_bus_ctrl.sv
// Motherboard bus controller: takes one CPU read/write command, runs a req/ack
// memory transaction with a watchdog, and reports busy/done/error on mobo_stat.
module mobo_bus_ctrl #(
  parameter int word_width     = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  input  logic [word_width-1:0] cpu_addr,
  input  logic [word_width-1:0] cpu_wdata,
  output logic [word_width-1:0] mobo_stat,
  output logic [word_width-1:0] cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [word_width-1:0] mem_addr,
  output logic [word_width-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [word_width-1:0] mem_rdata
);

  localparam int CW = $clog2(timeout_cycles + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  wr, wr_n, err_pend, err_pend_n;
  logic                  busy, busy_n, done, done_n, error, error_n, last_wr, last_wr_n;
  logic                  req_n, we_n;
  logic [word_width-1:0] rdata_n, addr_n, wdata_n;

  logic start, unused_ctrl;
  assign start       = mobo_ctrl[0];
  assign unused_ctrl = ^mobo_ctrl[word_width-1:2];

  assign mobo_stat = {{(word_width-4){1'b0}}, last_wr, error, done, busy};

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wr_n       = wr;
    err_pend_n = err_pend;
    busy_n     = busy;
    done_n     = done;
    error_n    = error;
    last_wr_n  = last_wr;
    req_n      = mem_req;
    we_n       = mem_we;
    rdata_n    = cpu_rdata;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        done_n = 1'b0;
        if (start) begin
          addr_n    = cpu_addr;
          wdata_n   = cpu_wdata;
          wr_n      = mobo_ctrl[1];
          error_n   = 1'b0;
          last_wr_n = 1'b0;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        req_n   = 1'b1;
        we_n    = wr;
        busy_n  = 1'b1;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // ack takes priority over a watchdog expiry in the same cycle
        if (mem_ack) begin
          req_n      = 1'b0;
          we_n       = 1'b0;
          err_pend_n = 1'b0;
          if (!wr) rdata_n = mem_rdata;
          state_n    = DONE;
        end else if (cnt == CW'(timeout_cycles - 1)) begin
          req_n      = 1'b0;
          we_n       = 1'b0;
          err_pend_n = 1'b1;
          cnt_n      = CW'(timeout_cycles);
          state_n    = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        // status publishes here, so done tracks start for the CPU handshake
        busy_n    = 1'b0;
        error_n   = err_pend;
        last_wr_n = wr;
        done_n    = start;
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr        <= 1'b0;
      err_pend  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      last_wr   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      wr        <= wr_n;
      err_pend  <= err_pend_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      last_wr   <= last_wr_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      cpu_rdata <= rdata_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_mobo_bus_ctrl.sv
// Self-checking bench for mobo_bus_ctrl: scoreboarded read/write/timeout/reset scenarios.
module tb_mobo_bus_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] mobo_ctrl = '0, cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mobo_stat, cpu_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we;

  int errs = 0, checks = 0;

  typedef struct {
    int          lat;
    logic [31:0] stat;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic        mwe;
  } exp_t;
  exp_t exp_q[$];

  mobo_bus_ctrl #(.word_width(32), .timeout_cycles(4)) dut (
    .clk(clk), .rst(rst), .mobo_ctrl(mobo_ctrl), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .mobo_stat(mobo_stat), .cpu_rdata(cpu_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Drives one command; k counts negedges after the accept edge, ack pulses in cycle k == ack_k.
  task automatic do_txn(input logic [31:0] ctrl, addr, wdata, rd, input int ack_k, ncyc,
                        output int lat, output int reqs, output logic [31:0] maddr,
                        output logic mwe, output logic [31:0] mwdata,
                        output logic [31:0] stat_done, rdata_done, stat_end, stat_after,
                        output logic addr_ok, output logic req_at_done);
    logic prev;
    prev = 0; lat = -1; reqs = 0; addr_ok = 1; maddr = '0; mwe = 0; mwdata = '0;
    stat_done = 'x; rdata_done = 'x; req_at_done = 1'bx;
    @(negedge clk);
    mobo_ctrl = ctrl; cpu_addr = addr; cpu_wdata = wdata;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        reqs++; maddr = mem_addr; mwe = mem_we; mwdata = mem_wdata;
      end
      if (mem_req && mem_addr !== addr) addr_ok = 0;
      prev = mem_req;
      if (mobo_stat[1] && lat < 0) begin
        lat = k; stat_done = mobo_stat; rdata_done = cpu_rdata; req_at_done = mem_req;
      end
      mem_ack   = (k == ack_k);
      mem_rdata = (k == ack_k) ? rd : $urandom;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
    end
    stat_end = mobo_stat;
    mem_ack = 0; mobo_ctrl = '0;
    @(negedge clk);
    stat_after = mobo_stat;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (mobo_stat !== 32'h0) begin errs++; $display("FAIL reset_stat: got %h want 0", mobo_stat); end
    checks++; if ({mem_req, mem_we} !== 2'b00) begin errs++; $display("FAIL reset_req_we: got %b want 00", {mem_req, mem_we}); end
    checks++; if ({cpu_rdata, mem_addr, mem_wdata} !== 96'h0) begin errs++; $display("FAIL reset_data: got %h/%h/%h want 0", cpu_rdata, mem_addr, mem_wdata); end
    rst = 0;
  endtask

  task automatic test_read;
    int lat, reqs; logic [31:0] ma, mwd, sd, rdd, se, sa; logic mwe, aok, rqd; exp_t e;
    exp_q.push_back('{lat: 5, stat: 32'h2, rdata: 32'hDEADBEEF, maddr: 32'h100, mwe: 1'b0});
    do_txn(32'h1, 32'h100, 32'h0, 32'hDEADBEEF, 3, 8, lat, reqs, ma, mwe, mwd, sd, rdd, se, sa, aok, rqd);
    e = exp_q.pop_front();
    checks++; if (ma !== e.maddr || mwe !== e.mwe) begin errs++; $display("FAIL read_req: got addr %h we %b want %h %b", ma, mwe, e.maddr, e.mwe); end
    checks++; if (lat !== e.lat) begin errs++; $display("FAIL read_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (sd !== e.stat) begin errs++; $display("FAIL read_stat: got %h want %h", sd, e.stat); end
    checks++; if (rdd !== e.rdata) begin errs++; $display("FAIL read_rdata: got %h want %h", rdd, e.rdata); end
    checks++; if (sa !== 32'h0) begin errs++; $display("FAIL read_drop_start: got %h want 0", sa); end
  endtask

  task automatic test_write;
    int lat, reqs; logic [31:0] ma, mwd, sd, rdd, se, sa; logic mwe, aok, rqd; exp_t e;
    exp_q.push_back('{lat: 3, stat: 32'hA, rdata: 32'hDEADBEEF, maddr: 32'h40, mwe: 1'b1});
    do_txn(32'h3, 32'h40, 32'h12345678, 32'hBAD0BAD0, 1, 6, lat, reqs, ma, mwe, mwd, sd, rdd, se, sa, aok, rqd);
    e = exp_q.pop_front();
    checks++; if (ma !== e.maddr || mwe !== e.mwe || mwd !== 32'h12345678) begin errs++; $display("FAIL write_req: got %h %b %h want %h %b 12345678", ma, mwe, mwd, e.maddr, e.mwe); end
    checks++; if (lat !== e.lat) begin errs++; $display("FAIL write_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (sd !== e.stat) begin errs++; $display("FAIL write_stat: got %h want %h", sd, e.stat); end
    checks++; if (rdd !== e.rdata) begin errs++; $display("FAIL write_rdata_kept: got %h want %h", rdd, e.rdata); end
  endtask

  task automatic test_timeout;
    int lat, reqs; logic [31:0] ma, mwd, sd, rdd, se, sa; logic mwe, aok, rqd; exp_t e;
    exp_q.push_back('{lat: 6, stat: 32'h6, rdata: 32'hDEADBEEF, maddr: 32'h200, mwe: 1'b0});
    do_txn(32'h1, 32'h200, 32'h0, 32'h11111111, 7, 10, lat, reqs, ma, mwe, mwd, sd, rdd, se, sa, aok, rqd);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) begin errs++; $display("FAIL timeout_latency: got %0d want %0d", lat, e.lat); end
    checks++; if (sd !== e.stat || rqd !== 1'b0) begin errs++; $display("FAIL timeout_stat: got %h req %b want %h req 0", sd, rqd, e.stat); end
    checks++; if (se !== e.stat || rdd !== e.rdata || cpu_rdata !== e.rdata) begin errs++; $display("FAIL timeout_late_ack: got stat %h rdata %h want %h %h", se, cpu_rdata, e.stat, e.rdata); end
    checks++; if (sa !== 32'h4) begin errs++; $display("FAIL timeout_error_held: got %h want 4", sa); end
    exp_q.push_back('{lat: 4, stat: 32'h2, rdata: 32'h0BADF00D, maddr: 32'h300, mwe: 1'b0});
    do_txn(32'h1, 32'h300, 32'h0, 32'h0BADF00D, 2, 6, lat, reqs, ma, mwe, mwd, sd, rdd, se, sa, aok, rqd);
    e = exp_q.pop_front();
    checks++; if (sd !== e.stat || rdd !== e.rdata || lat !== e.lat) begin errs++; $display("FAIL timeout_recover: got %h %h lat %0d want %h %h %0d", sd, rdd, lat, e.stat, e.rdata, e.lat); end
  endtask

  task automatic test_ack_at_limit;
    int lat, reqs; logic [31:0] ma, mwd, sd, rdd, se, sa; logic mwe, aok, rqd; exp_t e;
    exp_q.push_back('{lat: 6, stat: 32'h2, rdata: 32'hCAFEF00D, maddr: 32'h280, mwe: 1'b0});
    do_txn(32'h1, 32'h280, 32'h0, 32'hCAFEF00D, 4, 8, lat, reqs, ma, mwe, mwd, sd, rdd, se, sa, aok, rqd);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat || sd !== e.stat) begin errs++; $display("FAIL ack_at_limit_stat: got lat %0d stat %h want %0d %h", lat, sd, e.lat, e.stat); end
    checks++; if (rdd !== e.rdata) begin errs++; $display("FAIL ack_at_limit_rdata: got %h want %h", rdd, e.rdata); end
  endtask

  task automatic test_hold_start;
    int lat, reqs; logic [31:0] ma, mwd, sd, rdd, se, sa; logic mwe, aok, rqd; exp_t e;
    exp_q.push_back('{lat: 4, stat: 32'h2, rdata: 32'h5A5A0001, maddr: 32'h500, mwe: 1'b0});
    do_txn(32'h1, 32'h500, 32'h0, 32'h5A5A0001, 2, 16, lat, reqs, ma, mwe, mwd, sd, rdd, se, sa, aok, rqd);
    e = exp_q.pop_front();
    checks++; if (reqs !== 1) begin errs++; $display("FAIL hold_req_count: got %0d want 1", reqs); end
    checks++; if (aok !== 1'b1 || ma !== e.maddr) begin errs++; $display("FAIL hold_addr_stable: got %h ok %b want %h", ma, aok, e.maddr); end
    checks++; if (se !== e.stat || rdd !== e.rdata) begin errs++; $display("FAIL hold_done_held: got %h %h want %h %h", se, rdd, e.stat, e.rdata); end
  endtask

  task automatic test_reset_mid;
    int lat, reqs; logic [31:0] ma, mwd, sd, rdd, se, sa; logic mwe, aok, rqd; exp_t e;
    @(negedge clk);
    mobo_ctrl = 32'h3; cpu_addr = 32'h600; cpu_wdata = 32'h77;
    repeat (3) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rstmid_in_wait: got req %b want 1", mem_req); end
    #2 rst = 1;
    #1;
    checks++; if (mem_req !== 1'b0 || mobo_stat !== 32'h0 || mem_addr !== 32'h0) begin errs++; $display("FAIL rstmid_async: got req %b stat %h addr %h want 0 0 0", mem_req, mobo_stat, mem_addr); end
    mobo_ctrl = '0;
    @(negedge clk); rst = 0;
    exp_q.push_back('{lat: 3, stat: 32'h2, rdata: 32'h13572468, maddr: 32'h700, mwe: 1'b0});
    do_txn(32'h1, 32'h700, 32'h0, 32'h13572468, 1, 6, lat, reqs, ma, mwe, mwd, sd, rdd, se, sa, aok, rqd);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat || sd !== e.stat || rdd !== e.rdata || ma !== e.maddr) begin errs++; $display("FAIL rstmid_clean: got lat %0d stat %h rdata %h addr %h want %0d %h %h %h", lat, sd, rdd, ma, e.lat, e.stat, e.rdata, e.maddr); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_timeout;
    test_ack_at_limit;
    test_hold_start;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end
endmodule
